round_sequencer: RTL and testbench
==================================

// Module: round_sequencer
// PURPOSE
//  Game-round controller sitting between the button/clock front end and the game datapath/display.
//  Sequences each round:
//   - draws a pseudo-random target from a free-running LFSR;
//   - lets the player steer a counter with debounced up/down pulses;
//   - runs a per-round seconds timer from the 1 Hz tick;
//   - scores hits, charges lives on timeouts and halts at game over.
//  Outputs are binary; digit encoding and display muxing are done downstream.
// PARAMETERS
//  CNT_W       4      width of target and player count (range 0..2^CNT_W-1)
//  ROUND_SECS  10     seconds per round, 1..255
//  LIVES       3      lives per game, 1..3
//  MAX_SCORE   99     score saturation value, <=127
//  LFSR_SEED   8'hA5  LFSR reset value, must be non-zero
// PORTS
//  Clk100M    in   1      system clock, all logic on rising edge
//  resetN     in   1      synchronous active-low reset
//  tick1Hz    in   1      one-Clk100M-cycle pulse per second
//  startP     in   1      one-cycle start/restart pulse
//  upP        in   1      one-cycle increment pulse (debounced, blipped)
//  downP      in   1      one-cycle decrement pulse
//  state      out  3      IDLE=0 LOAD=1 PLAY=2 HIT=3 MISS=4 OVER=5
//  target     out  CNT_W  current round target
//  count      out  CNT_W  player counter
//  timeLeft   out  8      seconds remaining in round
//  score      out  7      rounds won, saturating
//  lives      out  2      lives remaining
//  hitP       out  1      one-cycle pulse in HIT state
//  missP      out  1      one-cycle pulse in MISS state
// BEHAVIOUR
//  Reset (resetN=0 at a clock edge, any state):
//   - state=IDLE, target=0, count=0, timeLeft=ROUND_SECS, score=0, lives=LIVES;
//   - hitP=missP=0, lfsr=LFSR_SEED;
//   - reset wins over every other input in the same cycle.
//  LFSR: 8-bit Galois, taps x^8+x^6+x^5+x^4+1, advances every cycle in every state incl. reset release.
//  IDLE: holds. startP -> LOAD.
//  LOAD (exactly 1 cycle):
//   - target<=lfsr[CNT_W-1:0], or lfsr[CNT_W-1:0]+1 (mod 2^CNT_W) if that value is 0;
//   - count<=0, timeLeft<=ROUND_SECS;
//   - -> PLAY.
//  PLAY, per cycle:
//   - upP alone: count+1, saturates at 2^CNT_W-1.
//   - downP alone: count-1, saturates at 0.
//   - upP and downP together: count unchanged.
//   - tick1Hz with timeLeft>0: timeLeft-1.
//   - Registered count==target -> HIT next edge. Compare uses the pre-update count, so HIT is entered
//     one cycle after the matching pulse; button pulses in that compare cycle are ignored.
//   - Timeout: tick1Hz with timeLeft==1 -> timeLeft=0, -> MISS.
//   - Match and timeout in the same cycle: HIT wins, timeLeft still decrements.
//   - startP ignored.
//  HIT (1 cycle): hitP=1, score<=min(score+1,MAX_SCORE); -> LOAD.
//  MISS (1 cycle): missP=1, lives<=lives-1; -> OVER if lives was 1, else LOAD.
//  OVER: all outputs frozen.
//   - startP: score<=0, lives<=LIVES, -> LOAD.
//   - up/down/tick ignored.
//  Pulse outputs are registered, high only while in HIT/MISS.
//  Latency: startP -> LOAD +1 cycle -> PLAY +2 cycles; match pulse -> hitP +2 cycles.
//  Round-to-round restart: HIT/MISS -> LOAD -> PLAY = 2 cycles.
// TESTING
//  1 Reset mid-PLAY (count=5, score=3) with resetN=0 one cycle
//    -> next cycle IDLE, count=0, score=0, lives=3, timeLeft=10.
//  2 startP, 1 cycle later force the known LFSR value, target=6; six upP pulses
//    -> hitP 2 cycles after the 6th, score=1, then LOAD, count=0.
//  3 PLAY with count=15, CNT_W=4: upP -> count stays 15.
//    count=0: downP -> stays 0. upP+downP same cycle -> unchanged.
//  4 No buttons, ten tick1Hz -> timeLeft 10..1 then 0, missP, lives 3->2, new round timeLeft=10.
//  5 Three timeouts from lives=3 -> state=OVER, lives=0.
//    up/down/tick ignored; startP -> LOAD, score=0, lives=3.
//  6 Match and final tick (timeLeft=1) same cycle -> HIT, lives unchanged, score+1.
//    Score at 99 + hit -> stays 99.

Source files
------------

// File: rtl/round_sequencer.sv
// Game-round controller: draws an LFSR target, tracks the player counter and round timer,
// scores hits, charges lives on timeouts and halts at game over.
module round_sequencer #(
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned ROUND_SECS = 10,
  parameter int unsigned LIVES      = 3,
  parameter int unsigned MAX_SCORE  = 99,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic             Clk100M,
  input  logic             resetN,
  input  logic             tick1Hz,
  input  logic             startP,
  input  logic             upP,
  input  logic             downP,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] target,
  output logic [CNT_W-1:0] count,
  output logic [7:0]       timeLeft,
  output logic [6:0]       score,
  output logic [1:0]       lives,
  output logic             hitP,
  output logic             missP
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PLAY = 3'd2,
    HIT  = 3'd3,
    MISS = 3'd4,
    OVER = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [7:0]       SECS_INIT  = 8'(ROUND_SECS);
  localparam logic [6:0]       SCORE_SAT  = 7'(MAX_SCORE);
  localparam logic [1:0]       LIVES_INIT = 2'(LIVES);

  state_t           st, st_nxt;
  logic [7:0]       lfsr, lfsr_nxt;
  logic [CNT_W-1:0] target_nxt, count_nxt, draw;
  logic [7:0]       time_nxt;
  logic [6:0]       score_nxt;
  logic [1:0]       lives_nxt;
  logic             match;

  assign state = st;

  always_ff @(posedge Clk100M) begin
    if (!resetN) begin
      st       <= IDLE;
      target   <= '0;
      count    <= '0;
      timeLeft <= SECS_INIT;
      score    <= '0;
      lives    <= LIVES_INIT;
      hitP     <= 1'b0;
      missP    <= 1'b0;
      lfsr     <= LFSR_SEED;
    end else begin
      st       <= st_nxt;
      target   <= target_nxt;
      count    <= count_nxt;
      timeLeft <= time_nxt;
      score    <= score_nxt;
      lives    <= lives_nxt;
      hitP     <= (st_nxt == HIT);
      missP    <= (st_nxt == MISS);
      lfsr     <= lfsr_nxt;
    end
  end

  always_comb begin
    st_nxt     = st;
    target_nxt = target;
    count_nxt  = count;
    time_nxt   = timeLeft;
    score_nxt  = score;
    lives_nxt  = lives;
    // Galois form of x^8+x^6+x^5+x^4+1, shifting right
    lfsr_nxt   = {1'b0, lfsr[7:1]} ^ ({8{lfsr[0]}} & 8'hB8);
    draw       = lfsr[CNT_W-1:0];
    if (draw == '0) draw = CNT_W'(1);
    match      = (count == target);

    case (st)
      IDLE: begin
        if (startP) st_nxt = LOAD;
      end
      LOAD: begin
        target_nxt = draw;
        count_nxt  = '0;
        time_nxt   = SECS_INIT;
        st_nxt     = PLAY;
      end
      PLAY: begin
        if (tick1Hz && timeLeft != 8'd0) time_nxt = timeLeft - 8'd1;
        // A match uses the pre-update count and masks that cycle's buttons and timeout
        if (match) begin
          st_nxt = HIT;
        end else begin
          if (upP && !downP && count != CNT_MAX) count_nxt = count + CNT_W'(1);
          if (downP && !upP && count != '0)      count_nxt = count - CNT_W'(1);
          if (tick1Hz && timeLeft == 8'd1)       st_nxt = MISS;
        end
      end
      HIT: begin
        score_nxt = (score < SCORE_SAT) ? score + 7'd1 : SCORE_SAT;
        st_nxt    = LOAD;
      end
      MISS: begin
        lives_nxt = lives - 2'd1;
        st_nxt    = (lives == 2'd1) ? OVER : LOAD;
      end
      OVER: begin
        if (startP) begin
          score_nxt = '0;
          lives_nxt = LIVES_INIT;
          st_nxt    = LOAD;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: constant vector table, directed corner sequences and
// randomized traffic compared against a behavioural game model.
module tb_round_sequencer;

  logic       Clk100M = 1'b0;
  logic       resetN, tick1Hz, startP, upP, downP;
  logic [2:0] state;
  logic [3:0] target, count;
  logic [7:0] timeLeft;
  logic [6:0] score;
  logic [1:0] lives;
  logic       hitP, missP;

  round_sequencer #(
    .CNT_W(4), .ROUND_SECS(10), .LIVES(3), .MAX_SCORE(99), .LFSR_SEED(8'hA5)
  ) dut (
    .Clk100M(Clk100M), .resetN(resetN), .tick1Hz(tick1Hz), .startP(startP),
    .upP(upP), .downP(downP), .state(state), .target(target), .count(count),
    .timeLeft(timeLeft), .score(score), .lives(lives), .hitP(hitP), .missP(missP)
  );

  always #5 Clk100M = ~Clk100M;

  int checks = 0;
  int errors = 0;

  // Game model: state numbers as listed for the state output
  int         m_st, m_tgt, m_cnt, m_tl, m_sc, m_lv;
  bit         m_hit, m_miss;
  logic [7:0] m_lfsr;

  typedef struct {
    bit s, u, d, t;
    int st, tg, cn, tl, sc, lv, hp, mp;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rn, input bit s, input bit u, input bit d, input bit t);
    int nst;
    if (!rn) begin
      m_st = 0; m_tgt = 0; m_cnt = 0; m_tl = 10; m_sc = 0; m_lv = 3;
      m_hit = 0; m_miss = 0; m_lfsr = 8'hA5;
      return;
    end
    nst = m_st;
    case (m_st)
      0: if (s) nst = 1;
      1: begin
        m_tgt = m_lfsr % 16;
        if (m_tgt == 0) m_tgt = 1;
        m_cnt = 0; m_tl = 10; nst = 2;
      end
      2: begin
        if (m_cnt == m_tgt) nst = 3;
        else begin
          if (u && !d && m_cnt < 15) m_cnt++;
          if (d && !u && m_cnt > 0)  m_cnt--;
          if (t && m_tl == 1) nst = 4;
        end
        if (t && m_tl > 0) m_tl--;
      end
      3: begin
        if (m_sc < 99) m_sc++;
        nst = 1;
      end
      4: begin
        m_lv--;
        nst = (m_lv == 0) ? 5 : 1;
      end
      5: if (s) begin m_sc = 0; m_lv = 3; nst = 1; end
      default: nst = 0;
    endcase
    m_st = nst;
    m_hit = (nst == 3);
    m_miss = (nst == 4);
    m_lfsr = lfsr_step(m_lfsr);
  endtask

  task automatic cycle(input bit rn, input bit s, input bit u, input bit d, input bit t);
    resetN = rn; startP = s; upP = u; downP = d; tick1Hz = t;
    @(posedge Clk100M);
    model_step(rn, s, u, d, t);
    #1;
    chk("state", state, m_st);
    chk("target", target, m_tgt);
    chk("count", count, m_cnt);
    chk("timeLeft", timeLeft, m_tl);
    chk("score", score, m_sc);
    chk("lives", lives, m_lv);
    chk("hitP", hitP, m_hit);
    chk("missP", missP, m_miss);
  endtask

  task automatic add(input bit s, u, d, t, input int st, tg, cn, tl, sc, lv, hp, mp);
    vec_t v;
    v.s = s; v.u = u; v.d = d; v.t = t;
    v.st = st; v.tg = tg; v.cn = cn; v.tl = tl; v.sc = sc; v.lv = lv; v.hp = hp; v.mp = mp;
    tbl.push_back(v);
  endtask

  task automatic go_play();
    for (int i = 0; i < 4 && m_st != 2; i++) cycle(1, 0, 0, 0, 0);
    chk("reach_play", state, 2);
  endtask

  task automatic win_round();
    go_play();
    for (int i = 0; i < 20 && m_cnt != m_tgt; i++)
      cycle(1, 0, m_cnt < m_tgt, m_cnt > m_tgt, 0);
    cycle(1, 0, 0, 0, 0);
    chk("win_hitP", hitP, 1);
    cycle(1, 0, 0, 0, 0);
    chk("win_load", state, 1);
  endtask

  task automatic lose_round();
    go_play();
    for (int i = 0; i < 20 && m_st == 2; i++) cycle(1, 0, 0, 0, 1);
    chk("lose_missP", missP, 1);
    cycle(1, 0, 0, 0, 0);
  endtask

  initial begin
    int  sc0;
    bit  found;
    logic [7:0] nxt;

    resetN = 0; startP = 0; upP = 0; downP = 0; tick1Hz = 0;
    m_st = 0; m_tgt = 0; m_cnt = 0; m_tl = 10; m_sc = 0; m_lv = 3;
    m_hit = 0; m_miss = 0; m_lfsr = 8'hA5;

    // Constant vectors from reset: first target drawn is 4'hA (lfsr A5 -> EA)
    add(1,0,0,0, 1, 0, 0,10,0,3,0,0);
    add(0,0,0,0, 2,10, 0,10,0,3,0,0);
    add(0,0,1,0, 2,10, 0,10,0,3,0,0);
    add(0,1,1,0, 2,10, 0,10,0,3,0,0);
    add(0,1,0,0, 2,10, 1,10,0,3,0,0);
    add(0,1,1,0, 2,10, 1,10,0,3,0,0);
    add(0,0,1,0, 2,10, 0,10,0,3,0,0);
    add(0,0,0,1, 2,10, 0, 9,0,3,0,0);
    add(0,1,0,1, 2,10, 1, 8,0,3,0,0);
    add(1,0,0,0, 2,10, 1, 8,0,3,0,0);
    for (int i = 2; i <= 10; i++) add(0,1,0,0, 2,10, i, 8,0,3,0,0);
    add(0,1,0,0, 3,10,10, 8,0,3,1,0);
    add(0,0,0,0, 1,10,10, 8,1,3,0,0);

    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 1);
    chk("rst_state", state, 0);
    chk("rst_time", timeLeft, 10);
    chk("rst_lives", lives, 3);
    foreach (tbl[i]) begin
      cycle(1, tbl[i].s, tbl[i].u, tbl[i].d, tbl[i].t);
      chk("tbl_state", state, tbl[i].st);
      chk("tbl_target", target, tbl[i].tg);
      chk("tbl_count", count, tbl[i].cn);
      chk("tbl_time", timeLeft, tbl[i].tl);
      chk("tbl_score", score, tbl[i].sc);
      chk("tbl_lives", lives, tbl[i].lv);
      chk("tbl_hitP", hitP, tbl[i].hp);
      chk("tbl_missP", missP, tbl[i].mp);
    end

    // Ten ticks with no buttons: timeout, life lost, fresh round
    cycle(1, 0, 0, 0, 0);
    chk("to_play", state, 2);
    for (int i = 1; i <= 10; i++) begin
      cycle(1, 0, 0, 0, 1);
      chk("to_time", timeLeft, 10 - i);
      chk("to_state", state, (i == 10) ? 4 : 2);
    end
    chk("to_missP", missP, 1);
    cycle(1, 0, 0, 0, 0);
    chk("to_lives", lives, 2);
    chk("to_missP_low", missP, 0);
    cycle(1, 0, 0, 0, 0);
    chk("to_newtime", timeLeft, 10);

    // Remaining lives drain to game over; inputs other than start are ignored there
    lose_round();
    lose_round();
    chk("over_state", state, 5);
    chk("over_lives", lives, 0);
    cycle(1, 0, 1, 0, 1);
    cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 1);
    chk("over_hold", state, 5);
    chk("over_time", timeLeft, 0);
    cycle(1, 1, 0, 0, 0);
    chk("restart_state", state, 1);
    chk("restart_score", score, 0);
    chk("restart_lives", lives, 3);

    // Match coincides with the final tick: hit wins
    go_play();
    for (int i = 0; i < 9; i++) cycle(1, 0, 0, 0, 1);
    chk("mt_time1", timeLeft, 1);
    for (int i = 0; i < 20 && m_cnt != m_tgt; i++) cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 1);
    chk("mt_state", state, 3);
    chk("mt_time0", timeLeft, 0);
    chk("mt_hitP", hitP, 1);
    cycle(1, 0, 0, 0, 0);
    chk("mt_score", score, 1);
    chk("mt_lives", lives, 3);

    // Score saturation
    for (int i = 0; i < 120 && m_sc < 99; i++) win_round();
    chk("sat_reach", score, 99);
    win_round();
    chk("sat_hold", score, 99);

    // Time the start so the drawn target is 6
    cycle(0, 0, 0, 0, 0);
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      nxt = lfsr_step(m_lfsr);
      if (nxt[3:0] == 4'd6) found = 1;
      else cycle(1, 0, 0, 0, 0);
    end
    chk("t6_found", found, 1);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("t6_target", target, 6);
    for (int i = 1; i <= 6; i++) begin
      cycle(1, 0, 1, 0, 0);
      chk("t6_count", count, i);
    end
    chk("t6_hit_early", hitP, 0);
    cycle(1, 0, 0, 0, 0);
    chk("t6_hitP", hitP, 1);
    cycle(1, 0, 0, 0, 0);
    chk("t6_load", state, 1);
    chk("t6_score", score, 1);
    cycle(1, 0, 0, 0, 0);
    chk("t6_count0", count, 0);

    // Reset mid-play
    win_round();
    win_round();
    sc0 = m_sc;
    chk("mid_score", score, 3);
    go_play();
    for (int i = 0; i < 5 && m_cnt < m_tgt - 1; i++) cycle(1, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 1);
    chk("mid_rst_state", state, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_score", score, 0);
    chk("mid_rst_lives", lives, 3);
    chk("mid_rst_time", timeLeft, 10);
    chk("mid_rst_target", target, 0);
    if (sc0 != 3) $display("note: score before reset was %0d", sc0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++)
      cycle($urandom_range(0, 299) != 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
